// File: rtl/mux_8to2.sv
// Registered bit-window selector: captures OUT_W adjacent bits of data_in,
// starting at bit offset select and wrapping past the MSB, with a valid flag.
module mux_8to2 #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 2,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic [SEL_W-1:0]  select,
  input  logic              in_valid,
  output logic [OUT_W-1:0]  data_out,
  output logic              out_valid
);

  logic [OUT_W-1:0] win;
  logic [OUT_W-1:0] data_d, data_q;
  logic             valid_d, valid_q;

  // Index sum is kept to SEL_W bits so the dropped carry performs the wrap.
  always_comb begin
    win = '0;
    for (int k = 0; k < OUT_W; k++) begin
      win[k] = data_in[select + SEL_W'(k)];
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = in_valid;
    if (in_valid) begin
      data_d = win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_8to2.sv
// Self-checking bench for mux_8to2: rotation-based reference model checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_mux_8to2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic [2:0] select;
  logic       in_valid;
  logic [1:0] data_out;
  logic       out_valid;

  int checks = 0;
  int errors = 0;
  bit cmpEn  = 1'b0;

  logic [1:0] expData;
  logic       expValid;

  always #5 clk = ~clk;

  mux_8to2 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .select   (select),
    .in_valid (in_valid),
    .data_out (data_out),
    .out_valid(out_valid)
  );

  // Window = low bits of the word rotated right by select.
  function automatic logic [1:0] modelWindow(input logic [7:0] d, input int sel);
    logic [15:0] dd;
    dd = {d, d} >> sel;
    return dd[1:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expData  = 2'b00;
      expValid = 1'b0;
    end else begin
      expValid = in_valid;
      if (in_valid) expData = modelWindow(data_in, int'(select));
    end
  end

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmpEn) begin
      check("modelData", data_out, expData);
      check("modelValid", {1'b0, out_valid}, {1'b0, expValid});
    end
  end

  task automatic applyStimulus(input logic [7:0] d, input logic [2:0] sel, input logic v);
    data_in  = d;
    select   = sel;
    in_valid = v;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] expD, input logic expV);
    @(posedge clk);
    #1;
    check({name, "_data"}, data_out, expD);
    check({name, "_valid"}, {1'b0, out_valid}, {1'b0, expV});
  endtask

  typedef struct {
    logic [7:0] d;
    logic [2:0] sel;
    logic [1:0] exp;
  } vec_t;

  vec_t sweep[8] = '{
    '{8'b10101010, 3'd0, 2'b10},
    '{8'b11110000, 3'd1, 2'b00},
    '{8'b00001111, 3'd2, 2'b11},
    '{8'b10001000, 3'd3, 2'b01},
    '{8'b01010101, 3'd4, 2'b01},
    '{8'b11001100, 3'd5, 2'b10},
    '{8'b00110011, 3'd6, 2'b00},
    '{8'b11111111, 3'd7, 2'b11}
  };

  initial begin
    rst_n = 1'b1;
    applyStimulus(8'h00, 3'd0, 1'b0);
    #1 rst_n = 1'b0;
    #1 cmpEn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_data", data_out, 2'b00);
    check("reset_valid", {1'b0, out_valid}, 2'b00);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(sweep[i].d, sweep[i].sel, 1'b1);
      checkOutput($sformatf("sweep%0d", i), sweep[i].exp, 1'b1);
    end

    applyStimulus(8'b10000000, 3'd7, 1'b1);
    checkOutput("wrapHi", 2'b01, 1'b1);
    applyStimulus(8'b00000001, 3'd7, 1'b1);
    checkOutput("wrapLo", 2'b10, 1'b1);

    applyStimulus(8'b00000011, 3'd0, 1'b1);
    checkOutput("holdLoad", 2'b11, 1'b1);
    applyStimulus(8'h00, 3'd0, 1'b0);
    checkOutput("hold", 2'b11, 1'b0);
    checkOutput("hold2", 2'b11, 1'b0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(8'b00000101, 3'(i % 2), 1'b1);
      checkOutput($sformatf("b2b%0d", i), (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1);
    end

    // Mid-stream asynchronous reset while the register holds 11.
    applyStimulus(8'b11000000, 3'd6, 1'b1);
    checkOutput("preReset", 2'b11, 1'b1);
    rst_n = 1'b0;
    #1;
    check("asyncReset_data", data_out, 2'b00);
    check("asyncReset_valid", {1'b0, out_valid}, 2'b00);
    checkOutput("resetHeld", 2'b00, 1'b0);
    rst_n = 1'b1;
    applyStimulus(8'b00000110, 3'd1, 1'b1);
    checkOutput("firstCapture", 2'b11, 1'b1);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      @(posedge clk);
      #1;
    end

    applyStimulus(8'h00, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    cmpEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_8to2.md
# mux_8to2

Registered 8-to-2 bit-window selector. `select` picks a 2-bit window of adjacent bits from an 8-bit input word, wrapping from bit 7 to bit 0. The selected pair is captured into an output register on the clock edge. It sits on a datapath that extracts a 2-bit field at a run-time bit offset, and carries a one-bit valid qualifier alongside the data.

## Interface
Parameters:
- `DATA_W`, default 8: input word width; must be a power of two, at least 2.
- `OUT_W`, default 2: output window width; must satisfy 1 ≤ OUT_W ≤ DATA_W.
- `SEL_W`, default 3: select width; equals log2(DATA_W).

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `data_in`, input, DATA_W: source word.
- `select`, input, SEL_W: bit offset of the window's LSB.
- `in_valid`, input, 1: qualifies `data_in` and `select` this cycle.
- `data_out`, output, OUT_W: registered selected window.
- `out_valid`, output, 1: `data_out` was updated by the last edge.

## Operation
- Combinational window, for k = 0..OUT_W-1: `win[k] = data_in[(select + k) mod DATA_W]`.
- With the defaults: `win = {data_in[(select+1) mod 8], data_in[select]}`.
- Index arithmetic is modulo DATA_W, done on SEL_W bits; the natural truncation of the carry gives the wrap.
- Wrap-around: at select=7, `data_out[1] = data_in[0]` and `data_out[0] = data_in[7]`.
- Rising edge of `clk` with `in_valid`=1: `data_out <= win`, `out_valid <= 1`.
- Rising edge with `in_valid`=0: `data_out` holds its previous value, `out_valid <= 0`.
- All select values 0..DATA_W-1 are legal; there is no out-of-range case.
- No other state. No backpressure: the block accepts a new input every cycle.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on `data_out` and `out_valid` after edge N.
- Throughput is one word per cycle.
- Outputs are register outputs only; there is no combinational path from input to output.
- Reset values: `data_out` = 0, `out_valid` = 0.
- Reset behaviour:
  - Asserting `rst_n` low clears both outputs immediately, without waiting for a clock edge, including mid-stream.
  - While `rst_n` is low, edges are ignored.
  - The first capture happens on the first rising edge after `rst_n` deasserts, provided `in_valid`=1.
- Simultaneous change of `data_in` and `select` in one cycle: both are sampled together at the same edge; there is no ordering dependency.

## Test plan
- Reset: drive `rst_n`=0 between edges while `data_out`=2'b11 → `data_out`=00 and `out_valid`=0 immediately, before the next edge.
- Full sweep with `in_valid`=1, one vector per cycle; each row is `data_in`, `select` → `data_out` one cycle later:
  - 10101010, 000 → 10
  - 11110000, 001 → 00
  - 00001111, 010 → 11
  - 10001000, 011 → 01
  - 01010101, 100 → 01
  - 11001100, 101 → 10
  - 00110011, 110 → 00
  - 11111111, 111 → 11
- Wrap-around:
  - `data_in`=10000000, select=111 → `data_out`=01.
  - `data_in`=00000001, select=111 → `data_out`=10.
- Hold: capture 2'b11, then drop `in_valid` to 0 and change `data_in` to 0 → `data_out` stays 11, `out_valid`=0 after the next edge.
- Back-to-back: alternate select 000/001 every cycle on `data_in`=00000101 → `data_out` alternates 01, 10 each cycle and `out_valid` stays 1.
